// File: rtl/rdc_pkg.sv
// Shared definitions for the rotating segment display controller:
// FSM state encoding and the default code of an empty display slot.
package rdc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        HOLD   = 2'd2,
        ROTATE = 2'd3
    } rdc_state_e;

    // Wide all-ones value; instances slice it down to their code width.
    localparam logic [31:0] BLANK_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/rotate_display_ctrl_btn_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a debounced button.
// A button already held when reset releases does not produce a pulse.
module btn_edge_sync
    import rdc_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync_1;
    logic sync_2;
    logic prev;
    logic ready_1;
    logic ready_2;

    // prev is held high until the synchroniser output is trustworthy, so a
    // level present at reset release looks like "already pressed".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            ready_1 <= 1'b0;
            ready_2 <= 1'b0;
            prev    <= 1'b1;
        end else begin
            sync_1  <= btn;
            sync_2  <= sync_1;
            ready_1 <= 1'b1;
            ready_2 <= ready_1;
            prev    <= ready_2 ? sync_2 : 1'b1;
        end
    end

    assign pulse = sync_2 & ~prev;

endmodule

// File: rtl/rotate_display_ctrl.sv
// Load/hold/rotate controller for a multiplexed segment display.
// Optional build macro LOAD_BLINK_EN: blink the slot being loaded.
module rotate_display_ctrl
    import rdc_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int CODE_W      = 8,
    parameter int STEP_DIV    = 10000000,
    parameter int REFRESH_DIV = 10000,
    parameter logic [CODE_W-1:0] BLANK_CODE = BLANK_DEFAULT[CODE_W-1:0]
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_rotate,
    input  logic                  clear,
    input  logic                  dir,
    input  logic [CODE_W-1:0]     code_in,
    output logic [CODE_W-1:0]     pattern,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic [1:0]            state
);

    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int STEP_W = $clog2(STEP_DIV);
    localparam int SCAN_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    rdc_state_e state_q;
    rdc_state_e state_d;

    logic [NUM_DIGITS-1:0][CODE_W-1:0] slots;
    logic [IDX_W-1:0]  ptr;
    logic [STEP_W-1:0] step_cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic [IDX_W-1:0]  scan_idx;
    logic [CODE_W-1:0] disp;

    logic load_ev;
    logic clear_ev;
    logic tick;
    logic write_en;
    logic step_en;
    logic step_clr;
    logic ptr_clr;
    logic step_run;

    btn_edge_sync u_load_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (load_rotate),
        .pulse (load_ev)
    );

    btn_edge_sync u_clear_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (clear),
        .pulse (clear_ev)
    );

    assign tick = (step_cnt == STEP_W'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Clear beats everything; a load in ROTATE beats a simultaneous step.
    always_comb begin
        state_d  = state_q;
        write_en = 1'b0;
        step_en  = 1'b0;
        step_clr = 1'b0;
        ptr_clr  = 1'b0;
        if (clear_ev) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (load_ev) begin
                    state_d  = LOAD;
                    ptr_clr  = 1'b1;
                    step_clr = 1'b1;
                end
                LOAD: if (load_ev) begin
                    write_en = 1'b1;
                    if (ptr == IDX_W'(NUM_DIGITS - 1)) state_d = HOLD;
                end
                HOLD: if (load_ev) begin
                    state_d  = ROTATE;
                    step_clr = 1'b1;
                end
                ROTATE: begin
                    if (load_ev)   state_d = HOLD;
                    else if (tick) step_en = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef LOAD_BLINK_EN
    assign step_run = (state_q == ROTATE) || (state_q == LOAD);
`else
    assign step_run = (state_q == ROTATE);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots    <= {NUM_DIGITS{BLANK_CODE}};
            ptr      <= '0;
            step_cnt <= '0;
        end else if (clear_ev) begin
            slots    <= {NUM_DIGITS{BLANK_CODE}};
            ptr      <= '0;
            step_cnt <= '0;
        end else begin
            if (write_en) begin
                slots[ptr] <= code_in;
                ptr <= (ptr == IDX_W'(NUM_DIGITS - 1)) ? '0 : ptr + 1'b1;
            end else if (ptr_clr) begin
                ptr <= '0;
            end
            // Left moves content toward slot 0; right toward slot N-1.
            if (step_en) begin
                if (dir) slots <= {slots[NUM_DIGITS-2:0], slots[NUM_DIGITS-1]};
                else     slots <= {slots[0], slots[NUM_DIGITS-1:1]};
            end
            if (step_clr)      step_cnt <= '0;
            else if (step_run) step_cnt <= tick ? '0 : step_cnt + 1'b1;
        end
    end

`ifdef LOAD_BLINK_EN
    logic blink_blank;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                           blink_blank <= 1'b0;
        else if (clear_ev || step_clr)        blink_blank <= 1'b0;
        else if (state_q == LOAD && tick)     blink_blank <= ~blink_blank;
    end

    always_comb begin
        disp = slots[scan_idx];
        if (state_q == LOAD && scan_idx == ptr)
            disp = blink_blank ? BLANK_CODE : code_in;
    end
`else
    assign disp = slots[scan_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            pattern  <= BLANK_CODE;
        end else begin
            pattern <= disp;
            if (scan_cnt == SCAN_W'(REFRESH_DIV - 1)) begin
                scan_cnt <= '0;
                scan_idx <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    assign digit_sel = ~(NUM_DIGITS'(1) << scan_idx);
    assign state     = state_q;

endmodule

// File: doc/rotate_display_ctrl.md
ROTATE_DISPLAY_CTRL -- requirements
Module: rotate_display_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, number of display slots (2..8).
REQ-002 SHALL have parameter CODE_W, default 8, width of one segment code.
REQ-003 SHALL have parameter STEP_DIV, default 10000000, clk cycles per rotation step (>=2).
REQ-004 SHALL have parameter REFRESH_DIV, default 10000, clk cycles per digit scan slot (>=1).
REQ-005 SHALL have parameter BLANK_CODE, default all-ones CODE_W, segment code of an empty slot.
REQ-006 SHALL have port clk  input  1  single system clock; all flops on its rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port load_rotate  input  1  debounced level button, asynchronous to clk.
REQ-009 SHALL have port clear  input  1  debounced level button, asynchronous to clk.
REQ-010 SHALL have port dir  input  1  rotation direction, 0 = left, 1 = right, sampled per step.
REQ-011 SHALL have port code_in  input  CODE_W  code written on load.
REQ-012 SHALL have port pattern  output  CODE_W  segment code of the currently scanned slot.
REQ-013 SHALL have port digit_sel  output  NUM_DIGITS  active-low one-hot digit enable.
REQ-014 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-015 SHALL pass load_rotate and clear through 2-flop synchronisers plus rising-edge detect; a single-cycle event pulse SHALL occur 3 clk edges after the pin is first sampled high, one pulse per press.
REQ-016 SHALL implement states IDLE=0, LOAD=1, HOLD=2, ROTATE=3.
REQ-017 IDLE: load event -> LOAD, load pointer = 0, no write.
REQ-018 LOAD: load event writes code_in to slot[pointer], pointer+1; write to slot NUM_DIGITS-1 -> HOLD, pointer = 0.
REQ-019 HOLD: load event -> ROTATE, step counter = 0; buffer static.
REQ-020 ROTATE: step counter counts 0..STEP_DIV-1 and wraps; at STEP_DIV-1 one rotation step occurs; load event -> HOLD.
REQ-021 Left step: slot[i] <= slot[i+1], slot[N-1] <= slot[0]; right step: slot[i] <= slot[i-1], slot[0] <= slot[N-1]; slot 0 is leftmost digit.
REQ-022 Clear event in any state -> IDLE, all slots = BLANK_CODE, pointer = 0, step counter = 0.
REQ-023 Clear and load events in same cycle: clear wins.
REQ-024 Load event and step tick in same cycle in ROTATE: -> HOLD, step suppressed.
REQ-025 Scan index cycles 0..NUM_DIGITS-1, advancing every REFRESH_DIV cycles in all states; digit_sel[idx]=0, others 1; pattern = slot[idx], registered (1-cycle latency from index).
REQ-026 Unwritten slots SHALL display BLANK_CODE.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, all slots=BLANK_CODE, pointer, step, scan counters and index = 0, synchroniser flops = 0.
REQ-028 Reset outputs: pattern=BLANK_CODE, digit_sel = all ones except bit 0 = 0, state=0.
REQ-029 A button held through reset release SHALL NOT generate an event.

Configuration
REQ-030 Macro LOAD_BLINK_EN defined: in LOAD, slot[pointer] SHALL display BLANK_CODE and code_in alternately, toggling every STEP_DIV cycles (blink counter reuses step counter, starting with code_in on LOAD entry); undefined: slot[pointer] shows BLANK_CODE until written. Other states unaffected.

Structure
REQ-031 Package rdc_pkg SHALL hold state encoding constants and the default BLANK_CODE value.
REQ-032 Sub-module btn_edge_sync (2-flop sync + rising-edge pulse) SHALL be instantiated twice.

Verification (NUM_DIGITS=4, CODE_W=8, STEP_DIV=4, REFRESH_DIV=2, BLANK_CODE=8'hFF)
REQ-033 Reset, then idle 20 cycles -> state=0, pattern=8'hFF for every scanned digit, digit_sel walks 1110,1101,1011,0111 every 2 cycles.
REQ-034 Four loads after entering LOAD with code_in 8'h11,8'h22,8'h33,8'h44 -> state=2, slots scan as 11,22,33,44.
REQ-035 From HOLD, load press, dir=0, wait 4 cycles -> slots 22,33,44,11; dir=1 next step -> 11,22,33,44.
REQ-036 Clear and load_rotate asserted same cycle in ROTATE -> state=0, all slots 8'hFF.
REQ-037 Load press timed to coincide with step tick in ROTATE -> state=2, slot order unchanged.
REQ-038 rst_n asserted mid-LOAD after two writes, load_rotate held high across release -> state=0, no event, all slots 8'hFF.
